sequence_generator: RTL

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator_if.sv | 28 ++
 rtl/sequence_generator.sv | 103 ++++++++++
 2 files changed

// File: rtl/sequence_generator_if.sv
// Request and register-file write bus of the sequence generator.
// The master side issues the requests and the slave side (the generator) drives the results.
interface sequence_generator_if;
  logic        start;
  logic        clr;
  logic [15:0] seed;
  logic        seed_load;
  logic        we;
  logic [7:0]  addr;
  logic [2:0]  wdata;
  logic [2:0]  d0;
  logic [2:0]  d1;
  logic [2:0]  d2;
  logic [2:0]  d3;
  logic [2:0]  d4;
  logic        busy;
  logic        done;

  modport master (
    output start, clr, seed, seed_load,
    input  we, addr, wdata, d0, d1, d2, d3, d4, busy, done
  );

  modport slave (
    input  start, clr, seed, seed_load,
    output we, addr, wdata, d0, d1, d2, d3, d4, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Writes DEPTH pseudo-random 3-bit words, no two consecutive words equal, on a key press.
// The words come from a free-running 16-bit Fibonacci LFSR.
module sequence_generator #(
  parameter int          DEPTH        = 5,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_generator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] lfsr;
  logic        start_q;
  logic        armed;
  logic [2:0]  index;
  logic [2:0]  d_q [5];

  logic [2:0]  candidate;
  logic        start_edge;
  logic        repeat_hit;
  logic        accept;
  logic        last_word;

  // armed stays low after reset until start is seen low, so a key held through reset is not a press.
  assign start_edge = bus.start & ~start_q & armed;
  assign candidate  = lfsr[2:0];
  assign repeat_hit = (index != 3'd0) && (candidate == bus.wdata);
  assign accept     = (state == WRITE) && !repeat_hit && !bus.clr;
  assign last_word  = (index == 3'(DEPTH - 1));

  // NOTE: every variable in an always_comb gets its default first; a missed path would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_edge)           state_next = WRITE;
      WRITE:   if (accept && last_word)  state_next = DONE;
      DONE:    if (start_edge)           state_next = WRITE;
      default:                           state_next = IDLE;
    endcase
    if (bus.clr) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // The LFSR is never reset by clr and never reaches zero: a zero seed is replaced by the default.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= SEED_DEFAULT;
    else if ((state == IDLE) && bus.seed_load && !bus.clr)
      lfsr <= (bus.seed == 16'h0000) ? SEED_DEFAULT : bus.seed;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // NOTE: the parallel word copies are a handful of flops, not a RAM, so they are reset with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b0;
      armed     <= 1'b0;
      index     <= 3'd0;
      bus.we    <= 1'b0;
      bus.addr  <= 8'd0;
      bus.wdata <= 3'd0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      for (int i = 0; i < 5; i++) d_q[i] <= 3'd0;
    end else begin
      start_q  <= bus.start;
      if (!bus.start) armed <= 1'b1;
      bus.we   <= accept;
      bus.busy <= (state_next == WRITE);
      bus.done <= (state == DONE) && (state_next == DONE);
      if (bus.clr) begin
        index     <= 3'd0;
        bus.addr  <= 8'd0;
        bus.wdata <= 3'd0;
        for (int i = 0; i < 5; i++) d_q[i] <= 3'd0;
      end else if (accept) begin
        bus.addr  <= {5'b0, index};
        bus.wdata <= candidate;
        if (index < 3'd5) d_q[index] <= candidate;
        index     <= index + 3'd1;
      end else if ((state != WRITE) && (state_next == WRITE)) begin
        index <= 3'd0;
      end
    end
  end

  assign bus.d0 = d_q[0];
  assign bus.d1 = d_q[1];
  assign bus.d2 = d_q[2];
  assign bus.d3 = d_q[3];
  assign bus.d4 = d_q[4];

endmodule
